// File: rtl/hdmi_ctrl_pkg.sv
// Shared definitions for the HDMI pass-through stream controller and the
// FIFO writer on the receive side: state encodings, default fill level and
// the layout of a FIFO word.
package hdmi_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_PRIME = 2'd2,
    ST_RUN   = 2'd3
  } state_t;

  // Minimum FIFO occupancy before the timing generator is released
  localparam logic [9:0] FILL_THRESH_DEF = 10'd256;

  // Width of the internal count of words discarded while searching for SOF
  localparam int FLUSH_W = 20;

  // FIFO word: 24-bit pixel followed by sync/enable flags and the SOF marker
  localparam int WORD_W         = 28;
  localparam int WORD_DE_BIT    = 24;
  localparam int WORD_VSYNC_BIT = 25;
  localparam int WORD_HSYNC_BIT = 26;
  localparam int WORD_SOF_BIT   = 27;

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter
  import hdmi_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == '1) return v;
    return v + 1'b1;
  endfunction

  // Count one event per cycle, holding at the maximum value
  always_ff @(posedge clk) begin
    if (rst)      count <= '0;
    else if (inc) count <= sat_inc(count);
  end

endmodule

// File: rtl/hdmi_stream_ctrl.sv
// Sequencer for the HDMI pass-through path (TX pixel clock domain).
// Flushes the pixel FIFO up to a start-of-frame word, waits for the FIFO to
// fill, then releases the timing generator and streams pixels. Underflow,
// frame misalignment and SOF-search timeout all fall back to FLUSH.
module hdmi_stream_ctrl
  import hdmi_ctrl_pkg::*;
#(
  parameter int                   LEVEL_W     = 10,
  parameter logic [LEVEL_W-1:0]   FILL_THRESH = FILL_THRESH_DEF,
  parameter logic [FLUSH_W-1:0]   FLUSH_MAX   = 20'd500000,
  parameter int                   CNT_W       = 16
) (
  input  logic               clk,
  input  logic               rstin,
  input  logic               enable,
  input  logic               fifo_empty,
  input  logic [LEVEL_W-1:0] fifo_level,
  input  logic               fifo_head_sof,
  input  logic               tmg_active,
  input  logic               tmg_frame_end,
  output logic               fifo_rd_en,
  output logic               tmg_restart,
  output logic               pix_de,
  output logic               locked,
  output logic [1:0]         state,
  output logic [CNT_W-1:0]   underflow_cnt,
  output logic [CNT_W-1:0]   resync_cnt
);

  state_t             st;
  state_t             st_nxt;
  logic [FLUSH_W-1:0] flush_cnt;
  logic               first_pix;
  logic               flush_pop;
  logic               underflow;
  logic               misalign;
  logic               timeout;
  logic               underflow_ev;
  logic               resync_ev;

  assign state = st;

  // Discarding a non-SOF word while searching for frame start
  assign flush_pop = (st == ST_FLUSH) && !fifo_empty && !fifo_head_sof;
  assign underflow = (st == ST_RUN) && tmg_active && fifo_empty;
  // First active pixel of a frame must be the SOF word
  assign misalign  = (st == ST_RUN) && first_pix && tmg_active && !fifo_head_sof;
  assign timeout   = flush_pop && (flush_cnt == FLUSH_MAX - 1'b1);

  // Counters hold while disabled; a combined underflow+misalign is one resync
  assign underflow_ev = enable && underflow;
  assign resync_ev    = enable && (underflow || misalign || timeout);

  // State register
  always_ff @(posedge clk) begin
    if (rstin) st <= ST_IDLE;
    else       st <= st_nxt;
  end

  // Next-state decision; enable low overrides every transition
  always_comb begin
    st_nxt = st;
    case (st)
      ST_IDLE:  st_nxt = ST_FLUSH;
      ST_FLUSH: if (!fifo_empty && fifo_head_sof)  st_nxt = ST_PRIME;
      ST_PRIME: if (fifo_level >= FILL_THRESH)     st_nxt = ST_RUN;
      ST_RUN:   if (underflow || misalign)         st_nxt = ST_FLUSH;
      default:  st_nxt = ST_IDLE;
    endcase
    if (!enable) st_nxt = ST_IDLE;
  end

  // Output decode from current state and inputs (no register stage)
  always_comb begin
    fifo_rd_en  = 1'b0;
    tmg_restart = 1'b1;
    pix_de      = 1'b0;
    locked      = 1'b0;
    case (st)
      ST_FLUSH: fifo_rd_en = flush_pop;
      ST_RUN: begin
        tmg_restart = 1'b0;
        locked      = 1'b1;
        pix_de      = tmg_active;
        fifo_rd_en  = tmg_active && !fifo_empty;
      end
      default: ;
    endcase
  end

  // SOF-search word count and first-pixel-of-frame tracking
  always_ff @(posedge clk) begin
    if (rstin) begin
      flush_cnt <= '0;
      first_pix <= 1'b0;
    end else begin
      // Outside FLUSH the count is held at zero so every entry starts fresh
      if (st != ST_FLUSH)  flush_cnt <= '0;
      else if (timeout)    flush_cnt <= '0;
      else if (flush_pop)  flush_cnt <= flush_cnt + 1'b1;
      // Armed outside RUN so the first frame after lock gets checked too
      if (st != ST_RUN)        first_pix <= 1'b1;
      else if (tmg_frame_end)  first_pix <= 1'b1;
      else if (tmg_active)     first_pix <= 1'b0;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_underflow_cnt (
    .clk   (clk),
    .rst   (rstin),
    .inc   (underflow_ev),
    .count (underflow_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_resync_cnt (
    .clk   (clk),
    .rst   (rstin),
    .inc   (resync_ev),
    .count (resync_cnt)
  );

endmodule
